// File: rtl/rf_wb_scheduler.sv
// rf_wb_scheduler: round-robin writeback arbiter onto the register-file write port with pending-write scoreboard
module rf_wb_scheduler #(
  parameter int DATA_W       = 32,
  parameter int NUM_SRC      = 3,
  parameter bit ZERO_DISCARD = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        wb_valid,
  input  logic [NUM_SRC*5-1:0]      wb_dst,
  input  logic [NUM_SRC*DATA_W-1:0] wb_data,
  output logic [NUM_SRC-1:0]        wb_ready,
  output logic                      rf_we,
  output logic [4:0]                rf_dst,
  output logic [DATA_W-1:0]         rf_wdata,
  input  logic                      iss_valid,
  input  logic [4:0]                iss_dst,
  output logic                      iss_ready,
  input  logic [4:0]                chk_src1,
  input  logic [4:0]                chk_src2,
  output logic                      busy1,
  output logic                      busy2,
  input  logic                      flush,
  output logic                      orphan_err
);
  localparam int PW = $clog2(NUM_SRC);
  logic [PW-1:0] rr_ptr, win;
  logic [31:0] pending, forgive, clr, set;
  logic [4:0] w_dst;
  logic [DATA_W-1:0] w_data;
  logic xfer, w_zero, iss_zero;
  always_comb begin
    int j;
    j = 0;
    wb_ready = '0;
    win = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      j = (int'(rr_ptr) + k) % NUM_SRC;
      if (wb_valid[j] && wb_ready == '0) begin
        wb_ready[j] = 1'b1;
        win = PW'(j);
      end
    end
  end
  assign xfer      = |wb_ready;
  assign w_dst     = wb_dst[5*win +: 5];
  assign w_data    = wb_data[DATA_W*win +: DATA_W];
  assign w_zero    = ZERO_DISCARD && w_dst == 5'd0;
  assign iss_zero  = ZERO_DISCARD && iss_dst == 5'd0;
  assign iss_ready = iss_valid & ~flush & (iss_zero | ~pending[iss_dst]);
  assign busy1     = pending[chk_src1];
  assign busy2     = pending[chk_src2];
  assign clr       = rf_we ? 32'd1 << rf_dst : '0;
  assign set       = (iss_ready && !iss_zero) ? 32'd1 << iss_dst : '0;
  // forgive remembers reservations dropped by flush so their late commits are not orphans
  always_ff @(posedge clk) begin
    if (!rst) begin
      rf_we      <= 1'b0;
      rf_dst     <= '0;
      rf_wdata   <= '0;
      pending    <= '0;
      forgive    <= '0;
      rr_ptr     <= '0;
      orphan_err <= 1'b0;
    end else begin
      rf_we <= xfer & ~w_zero;
      if (xfer && !w_zero) begin
        rf_dst   <= w_dst;
        rf_wdata <= w_data;
      end
      if (xfer) rr_ptr <= (win == PW'(NUM_SRC-1)) ? '0 : win + 1'b1;
      pending <= flush ? '0 : (pending & ~clr) | set;
      forgive <= (forgive | (flush ? pending : '0)) & ~clr;
      if (rf_we && !pending[rf_dst] && !forgive[rf_dst]) orphan_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_rf_wb_scheduler.sv
// tb_rf_wb_scheduler: directed scoreboard bench for the writeback scheduler
module tb_rf_wb_scheduler;
  logic clk = 0, rst = 0;
  logic [2:0] wb_valid = '0;
  logic [14:0] wb_dst = '0;
  logic [95:0] wb_data = '0;
  logic [2:0] wb_ready;
  logic rf_we, iss_valid = 0, iss_ready, busy1, busy2, flush = 0, orphan_err;
  logic [4:0] rf_dst, iss_dst = '0, chk_src1 = '0, chk_src2 = '0;
  logic [31:0] rf_wdata;
  int checks = 0, errors = 0, g;
  logic [4:0] src_d [3];
  logic [31:0] src_x [3];
  typedef struct {logic [4:0] d; logic [31:0] x;} wr_t;
  wr_t q[$];

  always #5 clk = ~clk;

  rf_wb_scheduler dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data),
    .wb_ready(wb_ready), .rf_we(rf_we), .rf_dst(rf_dst), .rf_wdata(rf_wdata),
    .iss_valid(iss_valid), .iss_dst(iss_dst), .iss_ready(iss_ready),
    .chk_src1(chk_src1), .chk_src2(chk_src2), .busy1(busy1), .busy2(busy2),
    .flush(flush), .orphan_err(orphan_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic src(input int i, input logic v, input logic [4:0] d, input logic [31:0] x);
    wb_valid[i] = v;
    wb_dst[5*i +: 5] = d;
    wb_data[32*i +: 32] = x;
  endtask

  task automatic push(input logic [4:0] d, input logic [31:0] x);
    wr_t e;
    e.d = d;
    e.x = x;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      if (q.size() == 0) chk("spurious_we", {31'd0, rf_we}, 32'd0);
      else begin
        wr_t e;
        e = q.pop_front();
        chk("rf_dst", {27'd0, rf_dst}, {27'd0, e.d});
        chk("rf_wdata", rf_wdata, e.x);
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      src_d[i] = 5'(i + 1);
      src_x[i] = 32'hA000_0000 + 32'(i);
      src(i, 1'b1, src_d[i], src_x[i]);
    end
    iss_valid = 1;
    iss_dst = 5'd5;
    chk_src1 = 5'd5;
    step();
    step();
    chk("rst_we", {31'd0, rf_we}, 0);
    chk("rst_grant", {29'd0, wb_ready}, 32'b001);
    chk("rst_iss_ready", {31'd0, iss_ready}, 1);
    chk("rst_busy1", {31'd0, busy1}, 0);
    chk("rst_orphan", {31'd0, orphan_err}, 0);
    iss_valid = 0;
    rst = 1;
    #1;
    for (int c = 0; c < 6; c++) begin
      g = c % 3;
      chk("rr_grant", {29'd0, wb_ready}, 32'd1 << g);
      push(src_d[g], src_x[g]);
      step();
      if (c == 5) wb_valid = '0;
      else begin
        src_x[g] = 32'hB000_0000 + 32'(c * 16 + g);
        src(g, 1'b1, src_d[g], src_x[g]);
      end
      #1;
    end
    step();
    chk("rr_drained", q.size(), 0);
    chk("rr_orphan_set", {31'd0, orphan_err}, 1);
    rst = 0;
    step();
    rst = 1;
    #1;
    chk("rst2_orphan", {31'd0, orphan_err}, 0);
    chk("rst2_we", {31'd0, rf_we}, 0);
    iss_valid = 1;
    iss_dst = 5'd5;
    #1;
    chk("haz_iss1", {31'd0, iss_ready}, 1);
    step();
    chk_src1 = 5'd5;
    #1;
    chk("haz_busy1", {31'd0, busy1}, 1);
    chk("haz_iss2", {31'd0, iss_ready}, 0);
    iss_valid = 0;
    src(1, 1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    chk("haz_grant", {29'd0, wb_ready}, 32'b010);
    push(5'd5, 32'hDEADBEEF);
    step();
    src(1, 1'b0, 5'd5, 32'hDEADBEEF);
    iss_valid = 1;
    #1;
    chk("haz_busy_commit", {31'd0, busy1}, 1);
    chk("haz_iss_commit", {31'd0, iss_ready}, 0);
    iss_valid = 0;
    step();
    chk("haz_busy_clear", {31'd0, busy1}, 0);
    chk("haz_no_orphan", {31'd0, orphan_err}, 0);
    iss_valid = 1;
    #1;
    chk("haz_reissue", {31'd0, iss_ready}, 1);
    step();
    iss_valid = 0;
    src(2, 1'b1, 5'd0, 32'h1234);
    #1;
    chk("zero_grant", {29'd0, wb_ready}, 32'b100);
    step();
    src(2, 1'b0, 5'd0, 32'h1234);
    iss_valid = 1;
    iss_dst = 5'd0;
    #1;
    chk("zero_we", {31'd0, rf_we}, 0);
    chk("zero_iss", {31'd0, iss_ready}, 1);
    step();
    iss_valid = 0;
    chk_src1 = 5'd0;
    #1;
    chk("zero_busy", {31'd0, busy1}, 0);
    src(0, 1'b1, 5'd7, 32'h7777);
    #1;
    chk("orph_grant", {29'd0, wb_ready}, 32'b001);
    push(5'd7, 32'h7777);
    step();
    src(0, 1'b0, 5'd7, 32'h7777);
    #1;
    chk("orph_pre", {31'd0, orphan_err}, 0);
    step();
    chk("orph_set", {31'd0, orphan_err}, 1);
    step();
    step();
    chk("orph_sticky", {31'd0, orphan_err}, 1);
    iss_valid = 1;
    iss_dst = 5'd3;
    step();
    iss_dst = 5'd4;
    step();
    chk_src1 = 5'd3;
    chk_src2 = 5'd4;
    iss_dst = 5'd9;
    flush = 1;
    #1;
    chk("fl_busy3", {31'd0, busy1}, 1);
    chk("fl_busy4", {31'd0, busy2}, 1);
    chk("fl_iss", {31'd0, iss_ready}, 0);
    step();
    flush = 0;
    iss_valid = 0;
    #1;
    chk("fl_clr3", {31'd0, busy1}, 0);
    chk("fl_clr4", {31'd0, busy2}, 0);
    chk_src1 = 5'd9;
    chk_src2 = 5'd5;
    #1;
    chk("fl_clr9", {31'd0, busy1}, 0);
    chk("fl_clr5", {31'd0, busy2}, 0);
    rst = 0;
    step();
    rst = 1;
    iss_valid = 1;
    iss_dst = 5'd6;
    #1;
    chk("fli_iss", {31'd0, iss_ready}, 1);
    step();
    iss_valid = 0;
    src(1, 1'b1, 5'd6, 32'h6666_0006);
    flush = 1;
    #1;
    chk("fli_grant", {29'd0, wb_ready}, 32'b010);
    push(5'd6, 32'h6666_0006);
    step();
    src(1, 1'b0, 5'd6, 32'h6666_0006);
    flush = 0;
    chk_src1 = 5'd6;
    #1;
    chk("fli_busy", {31'd0, busy1}, 0);
    step();
    chk("fli_no_orphan", {31'd0, orphan_err}, 0);
    step();
    chk("final_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
